// File: rtl/ir_nec_tx_if.sv
// NEC IR transmitter request/status bundle.
// master: the requester that drives code/start/hold; slave: the transmitter.
interface ir_nec_tx_if;
    logic [15:0] tx_code;   // [15:8] address, [7:0] command
    logic        tx_start;
    logic        tx_hold;
    logic        tx_busy;
    logic        tx_done;
    logic        ir_env;
    logic        ir_tx;

    modport master (
        output tx_code, tx_start, tx_hold,
        input  tx_busy, tx_done, ir_env, ir_tx
    );

    modport slave (
        input  tx_code, tx_start, tx_hold,
        output tx_busy, tx_done, ir_env, ir_tx
    );
endinterface

// File: rtl/ir_nec_tx.sv
// NEC infrared frame transmitter.
// Sends lead mark/space, 32 data bits (addr, ~addr, cmd, ~cmd, LSB first), a stop
// mark, then idles in GAP until the frame-to-frame spacing has elapsed.
// Optional macro IR_NEC_TX_REPEAT_EN: while tx_hold is high at GAP exit, NEC
// repeat codes are sent instead of returning to IDLE.
module ir_nec_tx #(
    parameter int UNIT_CYC    = 15188,
    parameter int CARRIER_CYC = 711,
    parameter int CARRIER_HI  = 237,
    parameter int FRAME_UNITS = 192
) (
    input  logic        clk27,
    input  logic        po_reset_n,
    ir_nec_tx_if.slave  bus
);
    localparam int UCW = $clog2(UNIT_CYC + 1);
    localparam int CCW = $clog2(CARRIER_CYC + 1);
    localparam int FW  = $clog2(FRAME_UNITS + 1);

    typedef enum logic [3:0] {
        IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE,
        STOP_MARK, GAP, RPT_MARK, RPT_SPACE, RPT_STOP
    } state_t;

    state_t           state, state_nxt;
    logic [UCW-1:0]   unit_cnt;
    logic [4:0]       st_units;
    logic [FW-1:0]    frm_cnt;
    logic [4:0]       bit_cnt;
    logic [31:0]      shreg;
    logic [CCW-1:0]   car_cnt, car_nxt;
    logic             mark_nxt, done_nxt;
    logic             env_q, tx_q, done_q;
    logic             unit_end, st_last, gap_end;

    // Length of each timed state in units; a data bit's space depends on its value.
    function automatic logic [4:0] st_dur(input state_t s, input logic b);
        case (s)
            LEAD_MARK:  st_dur = 5'd16;
            LEAD_SPACE: st_dur = 5'd8;
            BIT_SPACE:  st_dur = b ? 5'd3 : 5'd1;
            RPT_MARK:   st_dur = 5'd16;
            RPT_SPACE:  st_dur = 5'd4;
            default:    st_dur = 5'd1;
        endcase
    endfunction

    assign unit_end = (unit_cnt == UCW'(UNIT_CYC - 1));
    assign st_last  = unit_end && (st_units == st_dur(state, shreg[0]) - 5'd1);
    assign gap_end  = unit_end && (frm_cnt == FW'(FRAME_UNITS - 1));

`ifndef IR_NEC_TX_REPEAT_EN
    logic unused_hold;
    assign unused_hold = bus.tx_hold;
`endif

    // State register.
    always_ff @(posedge clk27 or negedge po_reset_n) begin
        if (!po_reset_n) state <= IDLE;
        else             state <= state_nxt;
    end

    // Next-state: every timed state leaves on the last cycle of its final unit.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (bus.tx_start) state_nxt = LEAD_MARK;
            LEAD_MARK:  if (st_last) state_nxt = LEAD_SPACE;
            LEAD_SPACE: if (st_last) state_nxt = BIT_MARK;
            BIT_MARK:   if (st_last) state_nxt = BIT_SPACE;
            BIT_SPACE:  if (st_last) state_nxt = (bit_cnt == 5'd31) ? STOP_MARK : BIT_MARK;
            STOP_MARK:  if (st_last) state_nxt = GAP;
            GAP: if (gap_end) begin
`ifdef IR_NEC_TX_REPEAT_EN
                state_nxt = bus.tx_hold ? RPT_MARK : IDLE;
`else
                state_nxt = IDLE;
`endif
            end
            RPT_MARK:   if (st_last) state_nxt = RPT_SPACE;
            RPT_SPACE:  if (st_last) state_nxt = RPT_STOP;
            RPT_STOP:   if (st_last) state_nxt = GAP;
            default:    state_nxt = IDLE;
        endcase
    end

    // Output decode: envelope and carrier phase for the coming cycle, done on GAP->IDLE.
    always_comb begin
        mark_nxt = (state_nxt == LEAD_MARK) || (state_nxt == BIT_MARK) ||
                   (state_nxt == STOP_MARK) || (state_nxt == RPT_MARK) ||
                   (state_nxt == RPT_STOP);
        car_nxt  = '0;
        if (mark_nxt && (state_nxt == state) && (car_cnt != CCW'(CARRIER_CYC - 1)))
            car_nxt = car_cnt + 1'b1;
        done_nxt = (state == GAP) && (state_nxt == IDLE);
    end

    // Registered outputs keep ir_tx glitch-free and aligned with the envelope.
    always_ff @(posedge clk27 or negedge po_reset_n) begin
        if (!po_reset_n) begin
            car_cnt <= '0;
            env_q   <= 1'b0;
            tx_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            car_cnt <= car_nxt;
            env_q   <= mark_nxt;
            tx_q    <= mark_nxt && (car_nxt < CCW'(CARRIER_HI));
            done_q  <= done_nxt;
        end
    end

    // Unit, state-unit, frame-unit and bit counters plus the data shift word.
    always_ff @(posedge clk27 or negedge po_reset_n) begin
        if (!po_reset_n) begin
            unit_cnt <= '0;
            st_units <= '0;
            frm_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else if (state == IDLE) begin
            unit_cnt <= '0;
            st_units <= '0;
            frm_cnt  <= '0;
            bit_cnt  <= '0;
            if (bus.tx_start)
                shreg <= {~bus.tx_code[7:0], bus.tx_code[7:0],
                          ~bus.tx_code[15:8], bus.tx_code[15:8]};
        end else begin
            unit_cnt <= unit_end ? '0 : unit_cnt + 1'b1;
            if (state_nxt != state || state == GAP) st_units <= '0;
            else if (unit_end)                      st_units <= st_units + 1'b1;
            // A repeat code starts a new frame period.
            if (state_nxt == RPT_MARK && state != RPT_MARK) frm_cnt <= '0;
            else if (unit_end)                              frm_cnt <= frm_cnt + 1'b1;
            if (state == BIT_SPACE && st_last) begin
                shreg   <= shreg >> 1;
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    assign bus.tx_busy = (state != IDLE);
    assign bus.tx_done = done_q;
    assign bus.ir_env  = env_q;
    assign bus.ir_tx   = tx_q;
endmodule
